dm_arb: RTL and testbench
=========================

# dm_arb

Two-requester arbiter and sequencer for the single-ported data memory `dm`. It shares `dm` between the pipeline MEM stage (CPU port) and a bulk loader/DMA port. The CPU has fixed priority. A starvation counter bounds DMA wait time, and a lock mode lets the DMA hold the memory for bounded bursts. It sits between the MEM stage, the DMA engine and `dm`, and drives `dm`'s `addr`, `wEn`, `BusW`, `ByteWidth` and `DmSignExt` directly.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive cycles DMA may be denied before it is force-granted one slot; 1..255.
- BURST_MAX, 16: maximum consecutive locked DMA grants; 1..255.

Ports. One clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  MEM stage access this cycle
- cpu_wen  in  1  CPU write
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_bw  in  2  CPU ByteWidth (11 word, 01 byte)
- cpu_sext  in  1  CPU byte-load sign extend
- cpu_rdata  out  32  combinational `dm_rdata` when CPU is granted, else 0
- cpu_stall  out  1  cpu_req & ~cpu_gnt, combinational
- dma_req, dma_wen, dma_addr[32], dma_wdata[32], dma_bw[2], dma_sext  in  DMA equivalents
- dma_lock  in  1  request burst ownership
- dma_ack  out  1  registered pulse: DMA access completed last cycle
- dma_rdata  out  32  registered read data, valid with dma_ack
- dm_addr, dm_wen, dm_wdata[32], dm_bw[2], dm_sext  out  to `dm`
- dm_rdata  in  32  `dm` BusR
- bw_err  out  1  registered pulse: granted access had illegal ByteWidth (00/10)

## Operation
State machine states:
- CPU_OWN: the default state.
- DMA_OWN: a DMA burst holds the memory.

Grant in CPU_OWN (combinational from registered state):
- DMA is granted if dma_req and starve_cnt == STARVE_MAX.
- Otherwise CPU is granted if cpu_req.
- Otherwise DMA is granted if dma_req.
- Otherwise nobody is granted.

Grant in DMA_OWN:
- DMA is granted if dma_req; CPU is stalled.

State transitions:
- CPU_OWN -> DMA_OWN when DMA is granted with dma_lock=1 and BURST_MAX>1; burst_cnt is loaded with 1.
- DMA_OWN -> CPU_OWN when any of these holds: dma_req=0, dma_lock=0, or burst_cnt reaches BURST_MAX on the current grant.
- burst_cnt increments on each granted DMA cycle in DMA_OWN.

starve_cnt:
- Increments, saturating at STARVE_MAX, on cycles where dma_req=1 and DMA is not granted.
- Clears on any DMA grant.

`dm` outputs:
- Driven by the granted requester's fields.
- With no grant: dm_addr=0, dm_wdata=0, dm_bw=2'b11, dm_sext=0, dm_wen=0.
- dm_wen is forced to 0 when rst=1, or when the granted bw is not 11/01. In the bad-width case bw_err pulses next cycle, so `dm` never performs its zero-fill write.

dma_ack and dma_rdata:
- dma_ack is set next cycle for every DMA grant, reads and writes alike.
- dma_rdata captures dm_rdata at the same edge; it holds its value otherwise.

## Timing
- CPU path latency is 0. A read is valid on cpu_rdata in the grant cycle; a write commits at the edge ending the grant cycle.
- DMA latency is 1. Access occurs in the grant cycle; dma_ack and dma_rdata appear on the following cycle. DMA must hold its request fields until the cycle it sees dma_ack; a request dropped before its grant is simply discarded.
- Simultaneous requests: CPU wins unless starve_cnt == STARVE_MAX or the state is DMA_OWN.
- Worst-case DMA wait is STARVE_MAX cycles.
- Worst-case CPU stall is BURST_MAX cycles, plus 1 cycle if a starvation slot immediately follows.
- Reset, including mid-burst: state=CPU_OWN, starve_cnt=0, burst_cnt=0, dma_ack=0, dma_rdata=0, bw_err=0. No write occurs in any cycle where rst=1.

## Structure
- Shared package `dm_arb_pkg`:
  - state encoding (CPU_OWN, DMA_OWN);
  - ByteWidth constants BW_WORD=2'b11 and BW_BYTE=2'b01;
  - a legal-width check function.
- No sub-module is needed; the counters and FSM stay inline.
- `dm` is instantiated alongside at integration level, not inside this block.

## Test plan
- CPU only: word write 0xDEADBEEF to 0x10, then read 0x10 → cpu_rdata=0xDEADBEEF in the read cycle, cpu_stall=0 throughout.
- Contention with STARVE_MAX=4: cpu_req and dma_req held high → DMA is granted exactly on the 5th cycle, dma_ack follows 1 cycle later, starve_cnt returns to 0, and cpu_stall=1 only in that cycle.
- Locked burst with BURST_MAX=16, dma_lock=1 and 20 DMA word writes → 16 consecutive grants, then one CPU slot (cpu_req=1), then the burst resumes; the CPU stall count is 16.
- Byte load: DMA reads 0x13 after the word 0x80000000 was written to 0x10, with dma_sext=1 → dma_rdata=0xFFFFFF80 with dma_ack.
- Illegal width: CPU write with cpu_bw=2'b00 → dm_wen=0, bw_err pulses next cycle, and memory is unchanged.
- Reset asserted mid-burst (state DMA_OWN, burst_cnt=7) → next cycle state=CPU_OWN, dma_ack=0, and a pending cpu_req is granted on the first cycle after rst falls.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and ByteWidth helpers for the data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } dm_arb_state_e;

    localparam logic [1:0] BW_WORD = 2'b11;
    localparam logic [1:0] BW_BYTE = 2'b01;
    localparam int unsigned CNT_W  = 8;

    function automatic logic bw_legal(input logic [1:0] bw);
        return (bw == BW_WORD) || (bw == BW_BYTE);
    endfunction

endpackage

// File: rtl/dm_arb.sv
// Shares the single-ported dm between the CPU (fixed priority, 0-cycle path) and a DMA port
// (ack 1 cycle after grant); a starvation counter and bounded lock bursts keep both sides live.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_bw,
    input  logic        cpu_sext,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_bw,
    input  logic        dma_sext,
    input  logic        dma_lock,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [31:0] dm_addr,
    output logic        dm_wen,
    output logic [31:0] dm_wdata,
    output logic [1:0]  dm_bw,
    output logic        dm_sext,
    input  logic [31:0] dm_rdata,
    output logic        bw_err
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);
    localparam logic             LOCK_OK    = (BURST_MAX > 1);

    dm_arb_state_e    state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             dma_ack_q;
    logic [31:0]      dma_rdata_q;
    logic             bw_err_q, bw_err_d;

    logic cpu_gnt, dma_gnt, dma_starved, any_gnt;
    logic gnt_wen, bw_ok;

    // Grant decision depends only on registered state plus this cycle's requests.
    always_comb begin
        cpu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        dma_starved = dma_req && (starve_q == STARVE_LIM);
        case (state_q)
            CPU_OWN: begin
                if (dma_starved)  dma_gnt = 1'b1;
                else if (cpu_req) cpu_gnt = 1'b1;
                else if (dma_req) dma_gnt = 1'b1;
            end
            DMA_OWN: dma_gnt = dma_req;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            CPU_OWN: begin
                if (dma_gnt && dma_lock && LOCK_OK) begin
                    state_d = DMA_OWN;
                    burst_d = CNT_W'(1);
                end
            end
            DMA_OWN: begin
                if (!dma_req || !dma_lock) begin
                    state_d = CPU_OWN;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + CNT_W'(1);
                    if (burst_d == BURST_LIM) begin
                        state_d = CPU_OWN;
                        burst_d = '0;
                    end
                end
            end
            default: begin
                state_d = CPU_OWN;
                burst_d = '0;
            end
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (dma_gnt)
            starve_d = '0;
        else if (dma_req && (starve_q != STARVE_LIM))
            starve_d = starve_q + CNT_W'(1);
    end

    always_comb begin
        dm_addr  = '0;
        dm_wdata = '0;
        dm_bw    = BW_WORD;
        dm_sext  = 1'b0;
        gnt_wen  = 1'b0;
        if (cpu_gnt) begin
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
            dm_bw    = cpu_bw;
            dm_sext  = cpu_sext;
            gnt_wen  = cpu_wen;
        end else if (dma_gnt) begin
            dm_addr  = dma_addr;
            dm_wdata = dma_wdata;
            dm_bw    = dma_bw;
            dm_sext  = dma_sext;
            gnt_wen  = dma_wen;
        end
    end

    assign any_gnt = cpu_gnt || dma_gnt;
    assign bw_ok   = bw_legal(dm_bw);
    // Suppressing the write on an illegal width keeps dm from zero-filling the word.
    assign dm_wen   = gnt_wen && bw_ok && !rst;
    assign bw_err_d = any_gnt && !bw_ok;

    assign cpu_rdata = cpu_gnt ? dm_rdata : '0;
    assign cpu_stall = cpu_req && !cpu_gnt;
    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;
    assign bw_err    = bw_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CPU_OWN;
            starve_q    <= '0;
            burst_q     <= '0;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= '0;
            bw_err_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            burst_q   <= burst_d;
            dma_ack_q <= dma_gnt;
            bw_err_q  <= bw_err_d;
            if (dma_gnt)
                dma_rdata_q <= dm_rdata;
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb with a behavioural little-endian dm model alongside.
module tb_dm_arb;
    import dm_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_wen, cpu_sext, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_bw;
    logic        dma_req, dma_wen, dma_sext, dma_lock, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [1:0]  dma_bw;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_wen, dm_sext, bw_err;
    logic [1:0]  dm_bw;

    int checks;
    int errors;

    dm_arb #(.STARVE_MAX(4), .BURST_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_bw(cpu_bw), .cpu_sext(cpu_sext), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_bw(dma_bw), .dma_sext(dma_sext), .dma_lock(dma_lock), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_bw(dm_bw),
        .dm_sext(dm_sext), .dm_rdata(dm_rdata), .bw_err(bw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word or byte access, illegal width write zero-fills the word.
    logic [31:0] mem [0:255];
    logic        mem_clr;
    logic [31:0] mw;
    logic [7:0]  mb;

    always_comb begin
        mw = mem[dm_addr[9:2]];
        mb = 8'(mw >> {dm_addr[1:0], 3'b000});
        if (dm_bw == BW_WORD)
            dm_rdata = mw;
        else if (dm_bw == BW_BYTE)
            dm_rdata = dm_sext ? {{24{mb[7]}}, mb} : {24'h0, mb};
        else
            dm_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (dm_wen) begin
            if (dm_bw == BW_WORD)
                mem[dm_addr[9:2]] <= dm_wdata;
            else if (dm_bw == BW_BYTE)
                mem[dm_addr[9:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_wdata[7:0];
            else
                mem[dm_addr[9:2]] <= 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] bw, input logic sext);
        cpu_req = req; cpu_wen = wen; cpu_addr = addr;
        cpu_wdata = wdata; cpu_bw = bw; cpu_sext = sext;
    endtask

    task automatic set_dma(input logic req, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] bw, input logic sext,
                           input logic lock);
        dma_req = req; dma_wen = wen; dma_addr = addr;
        dma_wdata = wdata; dma_bw = bw; dma_sext = sext; dma_lock = lock;
    endtask

    initial begin
        int k;
        int stalls;
        logic g, exp_g, exp_s, exp_a;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        mem_clr = 1'b1;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0, 1'b0);

        @(negedge clk);
        chk("rst_dma_ack", 32'(dma_ack), 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        chk("rst_bw_err", 32'(bw_err), 32'h0);
        chk("rst_dm_wen", 32'(dm_wen), 32'h0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        tick;
        rst = 1'b0;
        mem_clr = 1'b0;

        // CPU alone: write then read back
        set_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, BW_WORD, 1'b0);
        @(negedge clk);
        chk("cpu_wr_stall", 32'(cpu_stall), 32'h0);
        chk("cpu_wr_wen", 32'(dm_wen), 32'h1);
        chk("cpu_wr_addr", dm_addr, 32'h10);
        tick;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, BW_WORD, 1'b0);
        @(negedge clk);
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_rd_stall", 32'(cpu_stall), 32'h0);
        tick;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0);
        @(negedge clk);
        chk("idle_cpu_rdata", cpu_rdata, 32'h0);
        chk("idle_dm_addr", dm_addr, 32'h0);
        chk("idle_dm_bw", 32'(dm_bw), 32'h3);

        // Contention: DMA wins on the 5th cycle; a second round shows starve_cnt restarted at 0
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 5; i++) begin
                tick;
                set_cpu(1'b1, 1'b0, 32'h10, 32'h0, BW_WORD, 1'b0);
                set_dma(1'b1, 1'b0, 32'h10, 32'h0, BW_WORD, 1'b0, 1'b0);
                @(negedge clk);
                chk($sformatf("contend_r%0d_c%0d_stall", r, i), 32'(cpu_stall), 32'(i == 5));
                chk($sformatf("contend_r%0d_c%0d_ack", r, i), 32'(dma_ack), 32'h0);
            end
            tick;
            set_dma(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("contend_r%0d_ack", r), 32'(dma_ack), 32'h1);
            chk($sformatf("contend_r%0d_rdata", r), dma_rdata, 32'hDEADBEEF);
            chk($sformatf("contend_r%0d_after_stall", r), 32'(cpu_stall), 32'h0);
        end

        // Byte loads through DMA and CPU
        tick;
        set_cpu(1'b1, 1'b1, 32'h10, 32'h80000000, BW_WORD, 1'b0);
        tick;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0);
        set_dma(1'b1, 1'b0, 32'h13, 32'h0, BW_BYTE, 1'b1, 1'b0);
        @(negedge clk);
        chk("byte_dma_addr", dm_addr, 32'h13);
        tick;
        set_dma(1'b1, 1'b0, 32'h13, 32'h0, BW_BYTE, 1'b0, 1'b0);
        @(negedge clk);
        chk("byte_sext_ack", 32'(dma_ack), 32'h1);
        chk("byte_sext_rdata", dma_rdata, 32'hFFFFFF80);
        tick;
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0, 1'b0);
        @(negedge clk);
        chk("byte_zext_ack", 32'(dma_ack), 32'h1);
        chk("byte_zext_rdata", dma_rdata, 32'h00000080);
        tick;
        set_cpu(1'b1, 1'b0, 32'h13, 32'h0, BW_BYTE, 1'b1);
        @(negedge clk);
        chk("byte_cpu_rdata", cpu_rdata, 32'hFFFFFF80);
        chk("byte_cpu_noack", 32'(dma_ack), 32'h0);

        // Illegal widths from both ports
        tick;
        set_cpu(1'b1, 1'b1, 32'h10, 32'h12345678, 2'b00, 1'b0);
        @(negedge clk);
        chk("badbw_cpu_wen", 32'(dm_wen), 32'h0);
        chk("badbw_cpu_err_early", 32'(bw_err), 32'h0);
        tick;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, BW_WORD, 1'b0);
        @(negedge clk);
        chk("badbw_cpu_err", 32'(bw_err), 32'h1);
        chk("badbw_cpu_mem", cpu_rdata, 32'h80000000);
        tick;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0);
        set_dma(1'b1, 1'b1, 32'h10, 32'h5555, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        chk("badbw_dma_wen", 32'(dm_wen), 32'h0);
        chk("badbw_dma_err_early", 32'(bw_err), 32'h0);
        tick;
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0, 1'b0);
        @(negedge clk);
        chk("badbw_dma_err", 32'(bw_err), 32'h1);
        chk("badbw_dma_ack", 32'(dma_ack), 32'h1);
        tick;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, BW_WORD, 1'b0);
        @(negedge clk);
        chk("badbw_dma_mem", cpu_rdata, 32'h80000000);
        chk("badbw_err_clear", 32'(bw_err), 32'h0);

        // Locked burst of 20 writes: starvation slot opens a 16-grant burst, one CPU slot, then 4 more
        k = 0;
        stalls = 0;
        for (int t = 0; t <= 25; t++) begin
            tick;
            set_cpu(t <= 20, 1'b0, 32'h10, 32'h0, BW_WORD, 1'b0);
            if (k < 20)
                set_dma(1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'(k), BW_WORD, 1'b0, 1'b1);
            else
                set_dma(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0, 1'b0);
            @(negedge clk);
            g     = dma_req && dm_wen && (dm_addr == 32'h100 + 32'(4 * k));
            exp_g = (t >= 4 && t <= 19) || (t >= 21 && t <= 24);
            exp_s = (t >= 4 && t <= 19);
            exp_a = (t >= 5 && t <= 20) || (t >= 22 && t <= 25);
            chk($sformatf("burst_t%0d_gnt", t), 32'(g), 32'(exp_g));
            chk($sformatf("burst_t%0d_stall", t), 32'(cpu_stall), 32'(exp_s));
            chk($sformatf("burst_t%0d_ack", t), 32'(dma_ack), 32'(exp_a));
            if (g) k++;
            if (cpu_stall) stalls++;
        end
        chk("burst_stall_count", 32'(stalls), 32'd16);
        chk("burst_write_count", 32'(k), 32'd20);
        chk("burst_mem_16", mem[8'h50], 32'd16);
        chk("burst_mem_19", mem[8'h53], 32'd19);

        // Reset in the middle of a locked burst
        for (int t = 0; t < 7; t++) begin
            tick;
            set_cpu(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0);
            set_dma(1'b1, 1'b1, 32'h180, 32'h11, BW_WORD, 1'b0, 1'b1);
        end
        tick;
        rst = 1'b1;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, BW_WORD, 1'b0);
        set_dma(1'b1, 1'b1, 32'h180, 32'hBAD, BW_WORD, 1'b0, 1'b1);
        @(negedge clk);
        chk("midrst_wen", 32'(dm_wen), 32'h0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("midrst_cpu_rdata", cpu_rdata, 32'h80000000);
        chk("midrst_dma_ack", 32'(dma_ack), 32'h0);
        chk("midrst_dma_rdata", dma_rdata, 32'h0);
        chk("midrst_bw_err", 32'(bw_err), 32'h0);
        chk("midrst_mem", mem[8'h60], 32'h11);

        tick;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, BW_WORD, 1'b0, 1'b0);
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
